// File: rtl/serial_port_responder.sv
// rtl/serial_port_responder.sv - serial IO endpoint: RX/TX byte FIFOs and 8N1 UART transmitter
module serial_port_responder #(
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] serial_in,
  output logic       serial_valid_in,
  output logic       serial_ready_in,
  input  logic [7:0] serial_out,
  input  logic       serial_rden_out,
  input  logic       serial_wren_out,
  input  logic [7:0] host_rx_data,
  input  logic       host_rx_valid,
  output logic       host_rx_ready,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       wr_drop,
  output logic       rd_underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   L_DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   L_CNT1  = (AW+1)'(1);
  localparam logic [AW-1:0] L_PTR1  = AW'(1);
  localparam logic [BW-1:0] L_BLAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] L_BONE  = BW'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rx_wptr, r_rx_rptr;
  logic [AW:0]   r_rx_cnt;
  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_tx_wptr, r_tx_rptr;
  logic [AW:0]   r_tx_cnt;

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_bcnt, w_bcnt_nxt;
  logic [2:0]    r_bidx, w_bidx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_uart_tx, w_tx_nxt;
  logic          r_wr_drop, r_rd_underflow;

  logic w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  logic w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic w_bit_end;
  logic [7:0] w_tx_head;

  assign w_rx_full  = (r_rx_cnt == L_DEPTH);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_push  = host_rx_valid && !w_rx_full;
  assign w_rx_pop   = serial_rden_out && !w_rx_empty;

  assign w_tx_full  = (r_tx_cnt == L_DEPTH);
  assign w_tx_empty = (r_tx_cnt == '0);
  // A write while full is dropped even if the UART frees a slot on the same edge.
  assign w_tx_push  = serial_wren_out && !w_tx_full;
  assign w_tx_head  = r_tx_mem[r_tx_rptr];
  assign w_bit_end  = (r_bcnt == L_BLAST);

  assign host_rx_ready   = !w_rx_full;
  assign serial_valid_in = !w_rx_empty;
  assign serial_in       = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr];
  assign serial_ready_in = !w_tx_full;
  assign uart_tx         = r_uart_tx;
  assign tx_busy         = (r_state != S_IDLE);
  assign wr_drop         = r_wr_drop;
  assign rd_underflow    = r_rd_underflow;

  // FIFO storage; contents are meaningless once pointers and counts are reset.
  always_ff @(posedge clock) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= host_rx_data;
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= serial_out;
  end

  // RX FIFO pointers and occupancy count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + L_PTR1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + L_PTR1;
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + L_CNT1;
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - L_CNT1;
    end
  end

  // TX FIFO pointers and occupancy count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + L_PTR1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + L_PTR1;
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + L_CNT1;
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - L_CNT1;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_drop      <= 1'b0;
      r_rd_underflow <= 1'b0;
    end else begin
      if (serial_wren_out && w_tx_full)  r_wr_drop      <= 1'b1;
      if (serial_rden_out && w_rx_empty) r_rd_underflow <= 1'b1;
    end
  end

  // UART state registers; reset forces the line idle immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bcnt    <= '0;
      r_bidx    <= '0;
      r_shift   <= '0;
      r_uart_tx <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_bidx    <= w_bidx_nxt;
      r_shift   <= w_shift_nxt;
      r_uart_tx <= w_tx_nxt;
    end
  end

  // UART next-state: each bit held CLKS_PER_BIT cycles, STOP chains straight into the next START.
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_bidx_nxt  = r_bidx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_uart_tx;
    w_tx_pop    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_tx_empty) begin
          w_tx_pop    = 1'b1;
          w_shift_nxt = w_tx_head;
          w_state_nxt = S_START;
          w_bcnt_nxt  = '0;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_bcnt_nxt  = '0;
          w_bidx_nxt  = '0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_bcnt_nxt = r_bcnt + L_BONE;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_bcnt_nxt = '0;
          if (r_bidx == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bidx_nxt  = r_bidx + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_bcnt_nxt = r_bcnt + L_BONE;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_bcnt_nxt = '0;
          if (!w_tx_empty) begin
            w_tx_pop    = 1'b1;
            w_shift_nxt = w_tx_head;
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_bcnt_nxt = r_bcnt + L_BONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/serial_port_responder.md
Name: serial_port_responder

Overview:
Device-side endpoint for the processor's serial IO interface. It is wired to the processor's serial_in, serial_valid_in, serial_ready_in, serial_out, serial_rden_out and serial_wren_out ports, and answers the reads and writes the processor's data memory issues on them. Bytes written by the processor are buffered in a TX FIFO and shifted out on a UART line (8N1, LSB first). Bytes from an external host byte stream are buffered in an RX FIFO and presented to the processor.

Parameters:
FIFO_DEPTH, 8, entries per FIFO; must be a power of 2 and at least 2.
CLKS_PER_BIT, 434, clock cycles per UART bit; must be at least 2.

Ports:
clock  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
serial_in  output  8  RX FIFO head byte presented to the processor.
serial_valid_in  output  1  RX FIFO non-empty.
serial_ready_in  output  1  TX FIFO not full.
serial_out  input  8  byte written by the processor.
serial_rden_out  input  1  processor read strobe; pops the RX FIFO.
serial_wren_out  input  1  processor write strobe; pushes serial_out into the TX FIFO.
host_rx_data  input  8  inbound host byte.
host_rx_valid  input  1  host_rx_data valid.
host_rx_ready  output  1  RX FIFO can accept a byte.
uart_tx  output  1  serial line; idle high.
tx_busy  output  1  UART frame in progress.
wr_drop  output  1  sticky: a processor write was dropped.
rd_underflow  output  1  sticky: a processor read arrived while the RX FIFO was empty.

Behaviour:
- Clock, reset and sequencing: one clock; reset is asynchronous and active-high; ports are named clock and reset.
- Reset values:
  - Both FIFOs empty; FSM in IDLE; uart_tx=1, tx_busy=0.
  - serial_valid_in=0, serial_in=8'h00, serial_ready_in=1, host_rx_ready=1.
  - wr_drop=0, rd_underflow=0.
- Reset mid-frame: aborts the frame immediately; uart_tx returns to 1 asynchronously; FIFO contents are discarded.
- FIFO structure: circular buffers with read and write pointers plus a count register. Full and empty derive from the registered count only.
- RX path:
  - Push on host_rx_valid && host_rx_ready, where host_rx_ready = !rx_full.
  - First-word-fall-through: serial_in = head byte when non-empty, 8'h00 when empty; serial_valid_in = !rx_empty.
  - Pop on serial_rden_out && !rx_empty.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap at FIFO_DEPTH.
  - serial_rden_out while empty: ignored; sets rd_underflow.
- TX path:
  - serial_ready_in = !tx_full.
  - Push on serial_wren_out && !tx_full.
  - serial_wren_out while full: byte discarded; sets wr_drop. This holds even if the UART pops in the same cycle.
  - Push and pop in the same cycle: count unchanged.
- Sticky flags: cleared only by reset.
- UART FSM states: IDLE, START, DATA, STOP. Baud counter bcnt counts 0..CLKS_PER_BIT-1; bit index bidx counts 0..7.
  - IDLE && !tx_empty: on the edge, load the shift register with the TX head, pop, enter START, bcnt=0, uart_tx<=0.
  - START: when bcnt reaches CLKS_PER_BIT-1, enter DATA with bidx=0 and uart_tx<=shift[0].
  - DATA: at each bit end, shift right and drive the next LSB. After bit 7 ends, enter STOP with uart_tx<=1.
  - STOP: at its end, if !tx_empty, pop and enter START directly (no idle gap, uart_tx<=0); otherwise enter IDLE.
  - uart_tx is registered; each bit is held exactly CLKS_PER_BIT cycles, so one frame is 10*CLKS_PER_BIT cycles.
  - The first start bit appears 2 cycles after the serial_wren_out cycle: one cycle to push, one cycle for IDLE to pop.
- tx_busy = (state != IDLE).

Test Plan:
Use CLKS_PER_BIT=4 and FIFO_DEPTH=4 unless stated.
- Reset: after reset, uart_tx=1, serial_ready_in=1, serial_valid_in=0, host_rx_ready=1, wr_drop=0, rd_underflow=0.
- Single TX byte: write 8'hA5 at cycle 0 -> uart_tx=0 on cycles 2-5, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. tx_busy=1 for 40 cycles, then 0.
- Back-to-back TX: write 8'h01 and 8'h80 on consecutive cycles -> two 40-cycle frames with no idle gap between them. Decoded bytes are 01, then 80.
- TX overflow: while a frame is running, write 5 bytes -> serial_ready_in=0 after the 4th byte; the 5th is dropped and wr_drop=1. The line then carries the first frame plus 4 more frames.
- RX path: host pushes 11, 22, 33, 44 -> host_rx_ready=0 when full, and serial_in=11 with serial_valid_in=1 immediately. A read pops to show 22; reads return 22, 33, 44, then serial_valid_in=0. A 5th read sets rd_underflow=1.
- Async reset mid-frame: assert reset during the DATA bits -> uart_tx=1 with no clock edge; FIFOs are empty and tx_busy=0.
